// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// the blank pattern and the active-low hex font.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low glyphs for 0..F with the decimal point off.
  localparam logic [7:0] FONT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-side inputs and display-pin outputs of the scan driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] DATA;
  logic [NUM_DIGITS-1:0]   DP;
  logic [NUM_DIGITS-1:0]   EN;
  logic                    LOAD;
  logic                    LZ_SUP;
  logic [7:0]              SEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME;

  modport master (
    output DATA, DP, EN, LOAD, LZ_SUP,
    input  SEG, AN, FRAME
  );

  modport slave (
    input  DATA, DP, EN, LOAD, LZ_SUP,
    output SEG, AN, FRAME
  );
endinterface

// File: rtl/seg7_font.sv
// Hex nibble to active-low segments a..g.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup; the decimal point is handled by the caller.
  always_comb begin
    seg = FONT[nibble][SEG_G:SEG_A];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered
// digit data, leading-zero suppression and per-slot anti-ghost blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                    pend_v_q, pend_v_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_sup;
  logic                    zero_above;
  logic                    show;
  logic [6:0]              font_seg;

  seg7_font u_font (
    .nibble (cur_nib),
    .seg    (font_seg)
  );

  // Prescaler and digit index; wrap marks the last cycle of the last slot.
  always_comb begin
    slot_end = (pre_q == PRE_LAST);
    wrap     = slot_end && (idx_q == IDX_LAST);
    pre_d    = slot_end ? '0 : pre_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: active only changes at a frame wrap, so a frame never tears.
  // A LOAD landing on the wrap cycle bypasses pending straight into active.
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    pend_v_d    = pend_v_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    if (wrap && bus.LOAD) begin
      act_data_d = bus.DATA;
      act_dp_d   = bus.DP;
      act_en_d   = bus.EN;
      pend_v_d   = 1'b0;
    end else begin
      if (wrap && pend_v_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        act_en_d   = pend_en_q;
        pend_v_d   = 1'b0;
      end
      if (bus.LOAD) begin
        pend_data_d = bus.DATA;
        pend_dp_d   = bus.DP;
        pend_en_d   = bus.EN;
        pend_v_d    = 1'b1;
      end
    end
  end

  // Select the current digit and decide whether it is lit this cycle.
  // Suppression walks down from the top digit; digit 0 always survives.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_en     = 1'b0;
    cur_sup    = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (act_data_q[4*i +: 4] == 4'h0);
      if (IW'(i) == idx_q) begin
        cur_nib = act_data_q[4*i +: 4];
        cur_dp  = act_dp_q[i];
        cur_en  = act_en_q[i];
        cur_sup = bus.LZ_SUP && zero_above && (i != 0);
      end
    end
    show = cur_en && !cur_sup &&
           ((BLANK_CYCLES == 0) || (pre_q >= BLANK_END));
  end

  // Output pattern for the next registered cycle.
  always_comb begin
    seg_d   = SEG_OFF;
    an_d    = '1;
    frame_d = wrap;
    if (show) begin
      seg_d = {~cur_dp, font_seg};
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == idx_q) an_d[i] = 1'b0;
      end
    end
  end

  // All state, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_v_q    <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_en_q    <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      pend_v_q    <= pend_v_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.SEG   = seg_q;
  assign bus.AN    = an_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4 cycles/slot, 1 blank).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BC = 1;
  localparam int FRAME_LEN = ND * CD;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
    int         cyc;
  } exp_t;

  localparam logic [7:0] GLYPH [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  exp_t expq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Reference model: time since reset, the frame that is on screen and the
  // frame waiting to go up at the next frame boundary.
  int   t = 0;
  int   m_digit [ND];
  bit   m_dp    [ND];
  bit   m_en    [ND];
  int   p_digit [ND];
  bit   p_dp    [ND];
  bit   p_en    [ND];
  bit   p_valid = 0;

  logic [15:0] c_data = '0;
  logic [3:0]  c_dp   = '0;
  logic [3:0]  c_en   = '0;
  logic        c_lz   = 1'b0;

  task automatic clear_model();
    for (int k = 0; k < ND; k++) begin
      m_digit[k] = 0; m_dp[k] = 0; m_en[k] = 0;
      p_digit[k] = 0; p_dp[k] = 0; p_en[k] = 0;
    end
    p_valid = 0;
    t = 0;
  endtask

  task automatic step(input bit r, input bit ld);
    exp_t x;
    int   phase, slot;
    bit   at_wrap, suppressed, lit;
    @(negedge clk);
    rst        = r;
    bus.LOAD   = ld;
    bus.DATA   = c_data;
    bus.DP     = c_dp;
    bus.EN     = c_en;
    bus.LZ_SUP = c_lz;
    cyc++;
    x.cyc = cyc;
    if (r) begin
      x.seg = 8'hFF; x.an = 4'hF; x.frame = 1'b0;
      clear_model();
    end else begin
      phase   = t % CD;
      slot    = (t / CD) % ND;
      at_wrap = (t % FRAME_LEN) == FRAME_LEN - 1;
      suppressed = 0;
      if (c_lz && slot > 0) begin
        suppressed = 1;
        for (int k = slot; k < ND; k++) if (m_digit[k] != 0) suppressed = 0;
      end
      lit = m_en[slot] && !suppressed && (phase >= BC);
      x.frame = at_wrap;
      if (lit) begin
        x.seg = GLYPH[m_digit[slot]];
        if (m_dp[slot]) x.seg[7] = 1'b0;
        x.an = 4'hF;
        x.an[slot] = 1'b0;
      end else begin
        x.seg = 8'hFF; x.an = 4'hF;
      end
      if (at_wrap && ld) begin
        for (int k = 0; k < ND; k++) begin
          m_digit[k] = int'(c_data[4*k +: 4]); m_dp[k] = c_dp[k]; m_en[k] = c_en[k];
        end
        p_valid = 0;
      end else if (at_wrap && p_valid) begin
        for (int k = 0; k < ND; k++) begin
          m_digit[k] = p_digit[k]; m_dp[k] = p_dp[k]; m_en[k] = p_en[k];
        end
        p_valid = 0;
      end else if (ld) begin
        for (int k = 0; k < ND; k++) begin
          p_digit[k] = int'(c_data[4*k +: 4]); p_dp[k] = c_dp[k]; p_en[k] = c_en[k];
        end
        p_valid = 1;
      end
      t++;
    end
    expq.push_back(x);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    c_data = d; c_dp = p; c_en = e;
    step(1'b0, 1'b1);
  endtask

  // Advance until the model's frame position equals pos (at most one frame).
  task automatic run_to(input int pos);
    for (int k = 0; k < FRAME_LEN && (t % FRAME_LEN) != pos; k++) step(1'b0, 1'b0);
  endtask

  // Monitor: one registered output set per clock, compared against the queue.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      vectors++;
      if (bus.SEG !== e.seg || bus.AN !== e.an || bus.FRAME !== e.frame) begin
        miscompares++;
        $display("FAIL out cyc=%0d: SEG=%h AN=%h FRAME=%b, expected SEG=%h AN=%h FRAME=%b",
                 e.cyc, bus.SEG, bus.AN, bus.FRAME, e.seg, e.an, e.frame);
      end
    end
  end

  initial begin
    logic [15:0] rd;
    bus.DATA = '0; bus.DP = '0; bus.EN = '0; bus.LOAD = 1'b0; bus.LZ_SUP = 1'b0;
    clear_model();

    repeat (3) step(1'b1, 1'b0);
    run(36);

    load(16'h12AF, 4'h0, 4'hF);
    run(40);

    c_lz = 1'b1;
    load(16'h0050, 4'h0, 4'hF);
    run(36);
    load(16'h0000, 4'h0, 4'hF);
    run(36);
    c_lz = 1'b0;

    load(16'h12AF, 4'b0100, 4'b1110);
    run(36);

    run_to(6);
    load(16'h1111, 4'h0, 4'hF);
    run_to(FRAME_LEN - 1);
    load(16'h2345, 4'b0001, 4'hF);
    run(20);

    load(16'h9999, 4'hF, 4'hF);
    run(36);
    run_to(8);
    load(16'h7777, 4'h0, 4'hF);
    run_to(9);
    step(1'b1, 1'b0);
    run(40);

    for (int n = 0; n < 1500; n++) begin
      bit r, ld;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) c_lz = ~c_lz;
      if (ld) begin
        rd = 16'($urandom);
        for (int k = 0; k < ND; k++) if ($urandom_range(0, 1) == 0) rd[4*k +: 4] = 4'h0;
        c_data = rd;
        c_dp   = 4'($urandom);
        c_en   = 4'($urandom) | 4'($urandom);
      end
      step(r, ld);
    end
    step(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for an N-digit common-anode 7-segment display. It holds a double-buffered hex value per digit and scans one digit per refresh slot, driving active-low segment and anode lines. It also provides per-digit decimal point, per-digit enable, leading-zero suppression, anti-ghosting blanking and a frame-boundary pulse. It sits between the numeric datapath and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
CLK_DIV, 50000, CLK cycles per digit slot; must be at least 2.
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYCLES < CLK_DIV.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  synchronous, active-high reset.
DATA  in  4*NUM_DIGITS  hex nibbles; nibble i (DATA[4i+3:4i]) drives digit i, and digit 0 is the rightmost.
DP  in  NUM_DIGITS  decimal point per digit; 1 = lit.
EN  in  NUM_DIGITS  digit enable; 0 = digit always dark.
LOAD  in  1  one-cycle strobe that captures DATA, DP and EN into the pending buffer.
LZ_SUP  in  1  leading-zero suppression enable; level-sensitive and sampled every cycle.
SEG  out  8  active-low segments: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp.
AN  out  NUM_DIGITS  active-low anode select, one-hot-low.
FRAME  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset values: SEG=8'hFF, AN=all 1s, FRAME=0. The prescaler, digit index, pending buffer, pending-valid flag and active buffer all clear to 0. Because EN is 0, the display is dark after reset.
- Reset asserted mid-operation takes effect at the next edge, and any pending load is discarded.
- Prescaler: counts 0..CLK_DIV-1. When it reaches CLK_DIV-1 it wraps to 0 and the digit index advances by one, from NUM_DIGITS-1 back to 0.
- Index wrap: sets the internal wrap event. FRAME is registered and is high for exactly one cycle per NUM_DIGITS*CLK_DIV cycles.
- LOAD: captures inputs into the pending buffer and sets pending-valid.
- Active-buffer update: on a wrap event with pending-valid set, active <= pending and pending-valid clears.
- LOAD on the wrap cycle: the LOAD data is forwarded directly into the active buffer and pending-valid stays clear.
- Tearing: the displayed data never changes mid-frame.
- Digit shown: digit idx is shown when all of the following hold:
  - EN[idx]=1;
  - it is not suppressed;
  - prescaler >= BLANK_CYCLES.
- Shown digit outputs: AN has bit idx low and all others high. SEG[6:0] comes from the font, and SEG[7] = ~DP[idx].
- Not shown: AN = all 1s and SEG = 8'hFF.
- Leading-zero suppression: with LZ_SUP=1, digit i (i>0) is suppressed if active nibbles NUM_DIGITS-1 down to i are all 0. Digit 0 is never suppressed.
- Font, SEG values with dp off, for 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Latency: SEG, AN and FRAME are registered. They reflect the prescaler, index and active-buffer state of the previous cycle, giving one cycle of latency.
- Widths: the prescaler is $clog2(CLK_DIV) bits wide. The index is max(1,$clog2(NUM_DIGITS)) bits wide and never holds a value >= NUM_DIGITS.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry font constant array (8-bit, active-low);
  - SEG_OFF = 8'hFF;
  - the segment bit-position constants.
- One combinational sub-module, seg7_font, maps a 4-bit nibble to SEG[6:0].
- The scan counters, buffering, suppression logic and output registers stay in seg7_scan_driver.

Test Plan:
Bench configuration: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, so one frame is 16 cycles.
1. Hold RST high 3 cycles -> SEG=FF, AN=F, FRAME=0. After release, FRAME first pulses 16 cycles later and repeats every 16 cycles.
2. LOAD DATA=16'h12AF, EN=F, DP=0 -> after the next FRAME, one frame gives slot0 SEG=8E AN=E, slot1 SEG=88 AN=D, slot2 SEG=A4 AN=B, slot3 SEG=F9 AN=7. The first cycle of each slot has AN=F and SEG=FF.
3. LZ_SUP=1 and LOAD DATA=16'h0050, EN=F -> slots 3 and 2 show AN=F, SEG=FF; slot1 shows SEG=92 AN=D; slot0 shows SEG=C0 AN=E. With DATA=0, only digit 0 shows C0.
4. Set DP=4'b0100 -> slot2 shows SEG=24. Set EN=4'b1110 -> slot0 stays dark with AN=F.
5. LOAD DATA=16'h1111 mid-frame -> the old digits persist until the FRAME boundary, then 1s are shown. A second LOAD pulsed exactly on the wrap cycle is displayed from digit 0 of the frame that begins at that wrap.
6. Assert RST mid-slot 2 with the display active -> on the next cycle SEG=FF, AN=F and the pending load is dropped. After release, the scan restarts at digit 0 and the display stays dark until a new LOAD.
